// File: rtl/halton_fsm_param.sv
// halton_fsm_param
// Multi-dimensional Halton point generator. For sequence index k it produces DIMS van der
// Corput values, one per lane, each lane with its own base from {2,3,5,7}. Each lane is an
// unsigned Q0.WIDTH fraction: x_d = floor(vdc(k, b_d) * 2^WIDTH).
//
// Lanes are evaluated one after another by a shared digit engine (digit reversal by a
// constant-divisor mux) followed by a shared restoring divider (rev / pow scaled by 2^WIDTH).
//
// Parameters:
//   WIDTH     bit width of k_in and of each result lane (8..32)
//   DIMS      number of lanes (1..8)
//
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   start     launch request, sampled only while ready=1
//   k_in      sequence index, captured on accepted start
//   base_sel  lane d base code at bits [2d+1:2d]: 0->2, 1->3, 2->5, 3->7
//   result    lane d at bits [WIDTH*(d+1)-1:WIDTH*d]; valid when done=1
//   done      result valid
//   ready     idle, able to accept start
//   cnt_in    (LDS_BATCH_EN) number of points in the batch, 0 treated as 1
//   out_ack   (LDS_BATCH_EN) consumer accepts the current result
//
// Build option LDS_BATCH_EN: batch mode. done is held until out_ack, then the next index
// (k+1, wrapping) is computed until the batch count is exhausted. Without it, each start
// produces a single point and done is a one-cycle pulse.

module halton_fsm_param #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DIMS  = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [WIDTH-1:0]        k_in,
    input  logic [2*DIMS-1:0]       base_sel,
`ifdef LDS_BATCH_EN
    input  logic [WIDTH-1:0]        cnt_in,
    input  logic                    out_ack,
`endif
    output logic [WIDTH*DIMS-1:0]   result,
    output logic                    done,
    output logic                    ready
);

    // rev/pow need 3 extra bits: pow <= 7*k < 2^(WIDTH+3).
    localparam int unsigned RW = WIDTH + 3;
    localparam int unsigned DW = (DIMS > 1) ? $clog2(DIMS) : 1;
    localparam int unsigned CW = $clog2(WIDTH);

    typedef enum logic [2:0] {
        StIdle,
        StDigit,
        StDiv,
        StNextDim,
        StDone
    } state_e;

    state_e                  state_q, state_d;
    logic [WIDTH-1:0]        k_q, k_d;
    logic [2*DIMS-1:0]       sel_q, sel_d;
    logic [DW-1:0]           d_q, d_d;
    logic [WIDTH-1:0]        q_q, q_d;
    logic [RW-1:0]           rev_q, rev_d;
    logic [RW-1:0]           pow_q, pow_d;
    logic [RW:0]             rem_q, rem_d;
    logic [WIDTH-1:0]        quo_q, quo_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [WIDTH*DIMS-1:0]   result_q, result_d;
`ifdef LDS_BATCH_EN
    logic [WIDTH-1:0]        bcnt_q, bcnt_d;
`endif

    // Digit engine: one base-b digit of q per cycle.
    logic [1:0]              cur_sel;
    logic [2:0]              base3;
    logic [WIDTH-1:0]        q_div;
    logic [WIDTH-1:0]        q_rem;
    logic [RW-1:0]           rev_step;
    logic [RW-1:0]           pow_step;

    always_comb begin
        cur_sel = sel_q[2*int'(d_q) +: 2];
        base3   = 3'd2;
        q_div   = '0;
        unique case (cur_sel)
            2'd0: begin base3 = 3'd2; q_div = q_q / WIDTH'(2); end
            2'd1: begin base3 = 3'd3; q_div = q_q / WIDTH'(3); end
            2'd2: begin base3 = 3'd5; q_div = q_q / WIDTH'(5); end
            2'd3: begin base3 = 3'd7; q_div = q_q / WIDTH'(7); end
        endcase
        q_rem    = q_q - q_div * WIDTH'(base3);
        rev_step = rev_q * RW'(base3) + RW'(q_rem);
        pow_step = pow_q * RW'(base3);
    end

    // Restoring divider step: one quotient bit of rev*2^WIDTH/pow per cycle.
    // rem < pow < 2^RW always, so the shifted remainder fits in RW+1 bits.
    logic [RW:0]             rem_sh;
    logic [RW:0]             pow_ext;
    logic                    div_ge;
    logic [RW:0]             rem_nx;
    logic [WIDTH-1:0]        quo_nx;

    always_comb begin
        rem_sh  = rem_q << 1;
        pow_ext = {1'b0, pow_q};
        div_ge  = (rem_sh >= pow_ext);
        rem_nx  = div_ge ? (rem_sh - pow_ext) : rem_sh;
        quo_nx  = (quo_q << 1) | WIDTH'(div_ge);
    end

    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        sel_d    = sel_q;
        d_d      = d_q;
        q_d      = q_q;
        rev_d    = rev_q;
        pow_d    = pow_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        cnt_d    = cnt_q;
        result_d = result_q;
`ifdef LDS_BATCH_EN
        bcnt_d   = bcnt_q;
`endif

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    k_d     = k_in;
                    sel_d   = base_sel;
                    d_d     = '0;
                    q_d     = k_in;
                    rev_d   = '0;
                    pow_d   = RW'(1);
`ifdef LDS_BATCH_EN
                    bcnt_d  = (cnt_in == '0) ? WIDTH'(1) : cnt_in;
`endif
                    state_d = StDigit;
                end
            end

            StDigit: begin
                if (q_q == '0) begin
                    // All digits consumed (immediately for k == 0): hand rev/pow to divider.
                    rem_d   = {1'b0, rev_q};
                    quo_d   = '0;
                    cnt_d   = '0;
                    state_d = StDiv;
                end else begin
                    q_d   = q_div;
                    rev_d = rev_step;
                    pow_d = pow_step;
                end
            end

            StDiv: begin
                rem_d = rem_nx;
                quo_d = quo_nx;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    result_d[int'(d_q)*WIDTH +: WIDTH] = quo_nx;
                    state_d = StNextDim;
                end
            end

            StNextDim: begin
                if (d_q == DW'(DIMS - 1)) begin
                    state_d = StDone;
                end else begin
                    d_d     = d_q + DW'(1);
                    q_d     = k_q;
                    rev_d   = '0;
                    pow_d   = RW'(1);
                    state_d = StDigit;
                end
            end

            StDone: begin
`ifdef LDS_BATCH_EN
                if (out_ack) begin
                    k_d = k_q + WIDTH'(1);
                    if (bcnt_q <= WIDTH'(1)) begin
                        bcnt_d  = '0;
                        state_d = StIdle;
                    end else begin
                        bcnt_d  = bcnt_q - WIDTH'(1);
                        d_d     = '0;
                        q_d     = k_q + WIDTH'(1);
                        rev_d   = '0;
                        pow_d   = RW'(1);
                        state_d = StDigit;
                    end
                end
`else
                state_d = StIdle;
`endif
            end

            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            k_q      <= '0;
            sel_q    <= '0;
            d_q      <= '0;
            q_q      <= '0;
            rev_q    <= '0;
            pow_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
`ifdef LDS_BATCH_EN
            bcnt_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            sel_q    <= sel_d;
            d_q      <= d_d;
            q_q      <= q_d;
            rev_q    <= rev_d;
            pow_q    <= pow_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
`ifdef LDS_BATCH_EN
            bcnt_q   <= bcnt_d;
`endif
        end
    end

    assign ready  = (state_q == StIdle);
    assign done   = (state_q == StDone);
    assign result = result_q;

endmodule

// File: tb/tb_halton_fsm_param.sv
// Scoreboard bench for halton_fsm_param (WIDTH=32, DIMS=2). Stimulus pushes the expected
// {lane1, lane0} word; the monitor pops and compares whenever a result is presented.
module tb_halton_fsm_param;

    localparam int unsigned W = 32;
    localparam int unsigned D = 2;

    logic           clk      = 1'b0;
    logic           rst_n    = 1'b0;
    logic           start    = 1'b0;
    logic [W-1:0]   k_in     = '0;
    logic [2*D-1:0] base_sel = '0;
    logic [W*D-1:0] result;
    logic           done;
    logic           ready;
`ifdef LDS_BATCH_EN
    logic [W-1:0]   cnt_in   = 32'd1;
    logic           out_ack  = 1'b0;
`endif

    always #5 clk = ~clk;

    halton_fsm_param #(
        .WIDTH (W),
        .DIMS  (D)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .k_in     (k_in),
        .base_sel (base_sel),
`ifdef LDS_BATCH_EN
        .cnt_in   (cnt_in),
        .out_ack  (out_ack),
`endif
        .result   (result),
        .done     (done),
        .ready    (ready)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    logic [W*D-1:0] exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", name, got, want);
        end
    endtask

    // Monitor: a result is presented on done (batch: on the done/out_ack handshake).
    always @(negedge clk) begin
`ifdef LDS_BATCH_EN
        if (done && out_ack) begin
`else
        if (done) begin
`endif
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got result=%h expected no done", result);
            end else begin
                logic [W*D-1:0] want;
                want = exp_q.pop_front();
                check("result", result, want);
            end
        end
    end

    task automatic wait_ready();
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (ready) return;
        end
        total++;
        bad++;
        $display("FAIL ready_timeout: got ready=0 expected ready=1 within 300 cycles");
    endtask

    task automatic wait_done(output int t);
        t = -1;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (done) begin
                t = cyc;
                return;
            end
        end
        total++;
        bad++;
        $display("FAIL done_timeout: got done=0 expected done=1 within 600 cycles");
    endtask

    task automatic launch(input logic [W-1:0] k, input logic [2*D-1:0] sel, output int t0);
        wait_ready();
        @(posedge clk);
        #1;
        start    = 1'b1;
        k_in     = k;
        base_sel = sel;
        @(posedge clk);
        #1;
        start = 1'b0;
        t0    = cyc;
    endtask

    task automatic post_done();
`ifdef LDS_BATCH_EN
        @(posedge clk);
        #1 out_ack = 1'b1;
        @(posedge clk);
        #1 out_ack = 1'b0;
`endif
        @(negedge clk);
        check("done_drops", done, 0);
        check("ready_after_done", ready, 1);
    endtask

    task automatic run_point(input logic [W-1:0] k, input logic [2*D-1:0] sel,
                             input logic [W-1:0] e0, input logic [W-1:0] e1);
        int t0;
        int t1;
        exp_q.push_back({e1, e0});
        launch(k, sel, t0);
        wait_done(t1);
        post_done();
    endtask

    initial begin
        int t0;
        int t1;
        int seen;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_ready", ready, 1);
        check("reset_done", done, 0);
        check("reset_result", result, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Bases [2,3]
        run_point(32'd1, 4'b0100, 32'h8000_0000, 32'h5555_5555);
        run_point(32'd2, 4'b0100, 32'h4000_0000, 32'hAAAA_AAAA);
        run_point(32'd3, 4'b0100, 32'hC000_0000, 32'h1C71_C71C);
        run_point(32'd5, 4'b0100, 32'hA000_0000, 32'hC71C_71C7);
        // Bases [5,7] and swapped [7,5]
        run_point(32'd6, 4'b1110, 32'h3D70_A3D7, 32'hDB6D_B6DB);
        run_point(32'd6, 4'b1011, 32'hDB6D_B6DB, 32'h3D70_A3D7);

        // k=0: both lanes zero, 2*(0+32+1)+2 cycles from accept to done
        exp_q.push_back(64'h0);
        launch(32'd0, 4'b0100, t0);
        wait_done(t1);
        check("latency_k0", t1 - t0, 68);
        post_done();

        // start while busy must be ignored
        exp_q.push_back({32'h5555_5555, 32'h8000_0000});
        launch(32'd1, 4'b0100, t0);
        repeat (5) @(posedge clk);
        #1;
        start    = 1'b1;
        k_in     = 32'd2;
        base_sel = 4'b1110;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(t1);
        post_done();

        // Reset during DIV: no done, outputs back to reset values
        launch(32'd1, 4'b0100, t0);
        repeat (10) @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        check("abort_ready", ready, 1);
        check("abort_done", done, 0);
        check("abort_result", result, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        seen = 0;
        repeat (120) begin
            @(negedge clk);
            if (done) seen++;
        end
        check("no_done_after_abort", seen, 0);
        run_point(32'd1, 4'b0100, 32'h8000_0000, 32'h5555_5555);

`ifdef LDS_BATCH_EN
        // Batch of 2 from 0xFFFFFFFF with bases [2,2]: wraps to k=0
        exp_q.push_back({32'hFFFF_FFFF, 32'hFFFF_FFFF});
        exp_q.push_back(64'h0);
        wait_ready();
        @(posedge clk);
        #1;
        start    = 1'b1;
        k_in     = 32'hFFFF_FFFF;
        base_sel = 4'b0000;
        cnt_in   = 32'd2;
        @(posedge clk);
        #1;
        start  = 1'b0;
        cnt_in = 32'd1;
        for (int p = 0; p < 2; p++) begin
            wait_done(t1);
            repeat (3) begin
                @(negedge clk);
                check("batch_done_held", done, 1);
            end
            @(posedge clk);
            #1 out_ack = 1'b1;
            @(posedge clk);
            #1 out_ack = 1'b0;
        end
        @(negedge clk);
        check("batch_ready_after", ready, 1);
        check("batch_done_after", done, 0);
`endif

        repeat (4) @(posedge clk);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
